fsm_control: RTL and testbench
==============================

// Module: fsm_control
// PURPOSE
//  Top-level control FSM for the 4-channel, 2-class FIFO/arbiter datapath.
//  Drives state[3:0] into the arbiters and holds the FIFO almost-full and almost-empty thresholds.
//  Watches all FIFO empties and errors to report idle and to latch faults.
//  Sits beside the arbiter/FIFO cluster; its outputs go straight to the arbiter 'state' input and to the FIFO threshold ports.
// PARAMETERS
//  N_FIFO   12  FIFOs monitored (8 input-class + 4 output)
//  AW        3  threshold width; FIFO depth = 2**AW
//  AF_DEF    6  reset value of umbral_af
//  AE_DEF    1  reset value of umbral_ae
//  IDLE_HOLD 4  consecutive all-empty cycles before IDLE (only with FSM_IDLE_FILTER_EN)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_L      in   1       asynchronous reset, active-low
//  init         in   1       request (re)configuration
//  umbral_af_in in   AW      requested almost-full threshold
//  umbral_ae_in in   AW      requested almost-empty threshold
//  empties      in   N_FIFO  empty flag per FIFO
//  fifo_err     in   N_FIFO  overflow/underflow pulse per FIFO
//  state        out  4       current FSM state (encodings below)
//  umbral_af    out  AW      active almost-full threshold
//  umbral_ae    out  AW      active almost-empty threshold
//  idle         out  1       datapath drained, state==IDLE
//  error_out    out  N_FIFO  sticky per-FIFO error record
//  cfg_err      out  1       last threshold pair written in INIT was rejected
// BEHAVIOUR
//  - Encodings: RESET=4'd0, INIT=4'd1, IDLE=4'd2, ACTIVE=4'd3, ERROR=4'd4. Other codes are illegal; an illegal state goes to RESET on the next edge.
//  - reset_L=0 (async, any time, including mid-operation) forces state=RESET, umbral_af=AF_DEF, umbral_ae=AE_DEF, idle=0, error_out=0, cfg_err=0.
//  - All outputs are registered and change only on a rising clk edge.
//  - idle is decoded from the state register, so it is valid in the same cycle as state.
//  - Transition priority in every state except RESET: |fifo_err, then init, then normal flow.
//  - RESET -> INIT on the first edge after reset_L rises.
//  - INIT: on every cycle, thresholds load from the inputs when the pair is valid.
//      - Valid means 0 < ae_in < af_in <= 2**AW-1.
//      - A valid pair loads and clears cfg_err. An invalid pair keeps the old pair and sets cfg_err=1.
//      - INIT -> IDLE when init=0.
//  - IDLE: -> ACTIVE when any empties bit is 0; -> INIT when init=1.
//  - ACTIVE: -> IDLE when empties is all ones; -> INIT when init=1.
//  - ERROR: entered when any fifo_err bit is set, from INIT, IDLE or ACTIVE.
//      - error_out |= fifo_err on every cycle; error_out is sticky.
//      - ERROR is left only via reset_L. init is ignored in ERROR.
//  - Thresholds never change outside INIT. umbral_af_in and umbral_ae_in are don't-care elsewhere.
//  - fifo_err asserted in the same cycle as init: ERROR wins.
//  - Entering INIT from ACTIVE does not wait for drain. The arbiter stalls on state!=ACTIVE.
// CONFIGURATION
//  FSM_IDLE_FILTER_EN defined:
//    - ACTIVE->IDLE requires empties all ones for IDLE_HOLD consecutive cycles.
//    - A saturating counter clears on any empties 0 and on leaving ACTIVE.
//    - INIT->IDLE is unchanged.
//  FSM_IDLE_FILTER_EN undefined:
//    - ACTIVE->IDLE on the first all-empty cycle.
//    - No counter logic is synthesised.
// STRUCTURE
//  - Shared package fsm_pkg.vh: state encodings, STATE_W=4, AF_DEF/AE_DEF default localparams.
//    Shared with the arbiter and the probador.
//  - One natural sub-module, fsm_cfg_regs: threshold validation, threshold registers, cfg_err.
//  - Next-state logic and error record stay in fsm_control.
//  - Compare the behavioural model against the synthesised structural netlist (cmos cells).
// TESTING
//  1 reset_L=0 mid-ACTIVE, at a point away from a clk edge
//      -> state=0 and thresholds 6/1 immediately; after release: INIT, then IDLE once init=0.
//  2 INIT with af_in=5, ae_in=2, then init=0
//      -> umbral_af=5, umbral_ae=2, cfg_err=0, state=2, idle=1.
//  3 INIT with af_in=2, ae_in=3 (invalid)
//      -> thresholds keep their prior values, cfg_err=1; changing the inputs to a valid pair clears cfg_err.
//  4 IDLE, empties=12'hFFE for 3 cycles, then 12'hFFF
//      -> ACTIVE 1 cycle after 12'hFFE; IDLE 1 cycle after 12'hFFF.
//      -> With FSM_IDLE_FILTER_EN: IDLE 4 cycles after 12'hFFF.
//  5 ACTIVE, fifo_err=12'h010 with init=1 in the same cycle
//      -> state=4, error_out=12'h010; later fifo_err=12'h001 gives error_out=12'h011.
//      -> init toggling has no effect until reset.
//  6 Force an illegal state code (4'd9)
//      -> state=RESET on the next edge, then INIT.

Source files
------------

// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkg
// Purpose  : Shared FSM state encodings and reset-default thresholds for the
//            4-channel, 2-class FIFO/arbiter datapath control.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    localparam int STATE_W = 4;

    // State encodings seen by the arbiters on the 'state' bus.
    localparam logic [STATE_W-1:0] c_ST_RESET  = 4'd0;
    localparam logic [STATE_W-1:0] c_ST_INIT   = 4'd1;
    localparam logic [STATE_W-1:0] c_ST_IDLE   = 4'd2;
    localparam logic [STATE_W-1:0] c_ST_ACTIVE = 4'd3;
    localparam logic [STATE_W-1:0] c_ST_ERROR  = 4'd4;

    // Almost-full / almost-empty threshold values after reset.
    localparam int AF_DEF = 6;
    localparam int AE_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/fsm_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module   : fsm_cfg_regs
// Purpose  : Almost-full / almost-empty threshold registers. While loading is
//            enabled, a requested pair is accepted only if
//            0 < ae < af <= 2**AW-1; a rejected pair leaves the old thresholds
//            in place and raises cfg_err.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_cfg_regs #(
    parameter int AW     = 3,
    parameter int AF_DEF = 6,
    parameter int AE_DEF = 1
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          i_load,
    input  logic [AW-1:0] i_af,
    input  logic [AW-1:0] i_ae,
    output logic [AW-1:0] o_af,
    output logic [AW-1:0] o_ae,
    output logic          o_cfg_err
);

    logic [AW-1:0] r_af;
    logic [AW-1:0] r_ae;
    logic          r_cfg_err;
    logic          w_pair_ok;

    // The upper bound af <= 2**AW-1 is implied by the AW-bit width.
    assign w_pair_ok = (i_ae != '0) && (i_ae < i_af);

    // Load a valid pair or flag the rejection; hold everything otherwise.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_af      <= AF_DEF[AW-1:0];
            r_ae      <= AE_DEF[AW-1:0];
            r_cfg_err <= 1'b0;
        end else if (i_load) begin
            if (w_pair_ok) begin
                r_af      <= i_af;
                r_ae      <= i_ae;
                r_cfg_err <= 1'b0;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign o_af      = r_af;
    assign o_ae      = r_ae;
    assign o_cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: rtl/fsm_control.sv
`default_nettype none
// ============================================================================
// Module   : fsm_control
// Purpose  : Top-level control FSM for the 4-channel, 2-class FIFO/arbiter
//            datapath. Drives the arbiter state bus, owns the FIFO thresholds,
//            reports idle and keeps a sticky per-FIFO error record.
// Options  : FSM_IDLE_FILTER_EN - ACTIVE->IDLE only after IDLE_HOLD
//            consecutive all-empty cycles (default: first all-empty cycle).
// Revision : 1.0 - initial release
// ============================================================================
module fsm_control #(
    parameter int N_FIFO    = 12,
    parameter int AW        = 3,
    parameter int AF_DEF    = fsm_pkg::AF_DEF,
    parameter int AE_DEF    = fsm_pkg::AE_DEF
`ifdef FSM_IDLE_FILTER_EN
    ,
    parameter int IDLE_HOLD = 4
`endif
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        init,
    input  logic [AW-1:0]               umbral_af_in,
    input  logic [AW-1:0]               umbral_ae_in,
    input  logic [N_FIFO-1:0]           empties,
    input  logic [N_FIFO-1:0]           fifo_err,
    output logic [fsm_pkg::STATE_W-1:0] state,
    output logic [AW-1:0]               umbral_af,
    output logic [AW-1:0]               umbral_ae,
    output logic                        idle,
    output logic [N_FIFO-1:0]           error_out,
    output logic                        cfg_err
);

    import fsm_pkg::*;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [N_FIFO-1:0]  r_error_out;
    logic               w_any_err;
    logic               w_all_empty;
    logic               w_idle_ok;

    assign w_any_err   = |fifo_err;
    assign w_all_empty = &empties;

`ifdef FSM_IDLE_FILTER_EN
    localparam int c_HOLD_W = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;

    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                w_hold_done;
    logic                w_stay_empty;

    assign w_hold_done  = (r_hold_cnt == c_HOLD_W'(IDLE_HOLD - 1));
    assign w_stay_empty = (r_state == c_ST_ACTIVE) && (w_next_state == c_ST_ACTIVE)
                          && w_all_empty;
    assign w_idle_ok    = w_all_empty && w_hold_done;

    // Count consecutive all-empty ACTIVE cycles; clear on any busy FIFO or exit.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_hold_cnt <= '0;
        end else if (!w_stay_empty) begin
            r_hold_cnt <= '0;
        end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_idle_ok = w_all_empty;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: errors beat init, init beats normal flow; ERROR is terminal.
    always_comb begin
        w_next_state = c_ST_RESET;
        case (r_state)
            c_ST_RESET:  w_next_state = c_ST_INIT;
            c_ST_INIT: begin
                if (w_any_err)      w_next_state = c_ST_ERROR;
                else if (init)      w_next_state = c_ST_INIT;
                else                w_next_state = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                if (w_any_err)       w_next_state = c_ST_ERROR;
                else if (init)       w_next_state = c_ST_INIT;
                else if (!w_all_empty) w_next_state = c_ST_ACTIVE;
                else                 w_next_state = c_ST_IDLE;
            end
            c_ST_ACTIVE: begin
                if (w_any_err)      w_next_state = c_ST_ERROR;
                else if (init)      w_next_state = c_ST_INIT;
                else if (w_idle_ok) w_next_state = c_ST_IDLE;
                else                w_next_state = c_ST_ACTIVE;
            end
            c_ST_ERROR:  w_next_state = c_ST_ERROR;
            default:     w_next_state = c_ST_RESET;
        endcase
    end

    // Sticky per-FIFO error record.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_error_out <= '0;
        end else begin
            r_error_out <= r_error_out | fifo_err;
        end
    end

    fsm_cfg_regs #(
        .AW     (AW),
        .AF_DEF (AF_DEF),
        .AE_DEF (AE_DEF)
    ) u_cfg_regs (
        .clk       (clk),
        .reset_L   (reset_L),
        .i_load    (r_state == c_ST_INIT),
        .i_af      (umbral_af_in),
        .i_ae      (umbral_ae_in),
        .o_af      (umbral_af),
        .o_ae      (umbral_ae),
        .o_cfg_err (cfg_err)
    );

    assign state     = r_state;
    assign idle      = (r_state == c_ST_IDLE);
    assign error_out = r_error_out;

endmodule
`default_nettype wire

// File: tb/tb_fsm_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_control
// Purpose  : Self-checking bench for fsm_control. Directed stimulus pushes
//            hand-computed expected outputs into a scoreboard queue; a
//            separate monitor pops and compares against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_control;

    localparam int N_FIFO = 12;
    localparam int AW     = 3;
`ifdef FSM_IDLE_FILTER_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif

    typedef struct {
        string             name;
        logic [3:0]        st;
        logic [AW-1:0]     af;
        logic [AW-1:0]     ae;
        logic              idl;
        logic [N_FIFO-1:0] err;
        logic              cfg;
    } exp_t;

    logic              clk          = 1'b0;
    logic              reset_L      = 1'b1;
    logic              init         = 1'b0;
    logic [AW-1:0]     umbral_af_in = '0;
    logic [AW-1:0]     umbral_ae_in = '0;
    logic [N_FIFO-1:0] empties      = '1;
    logic [N_FIFO-1:0] fifo_err     = '0;
    logic [3:0]        state;
    logic [AW-1:0]     umbral_af;
    logic [AW-1:0]     umbral_ae;
    logic              idle;
    logic [N_FIFO-1:0] error_out;
    logic              cfg_err;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event ev_chk;

    fsm_control dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_af_in (umbral_af_in),
        .umbral_ae_in (umbral_ae_in),
        .empties      (empties),
        .fifo_err     (fifo_err),
        .state        (state),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .idle         (idle),
        .error_out    (error_out),
        .cfg_err      (cfg_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [3:0] st,
                              input logic [AW-1:0] af, input logic [AW-1:0] ae,
                              input logic idl, input logic [N_FIFO-1:0] err,
                              input logic cfg);
        exp_t e;
        e.name = name; e.st = st; e.af = af; e.ae = ae;
        e.idl = idl; e.err = err; e.cfg = cfg;
        sb_q.push_back(e);
        -> ev_chk;
        #1;
    endtask

    // Monitor: compare the DUT outputs against every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(ev_chk);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (state === e.st && umbral_af === e.af && umbral_ae === e.ae &&
                    idle === e.idl && error_out === e.err && cfg_err === e.cfg) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got state=%0d af=%0d ae=%0d idle=%b err=%h cfg_err=%b ; expected state=%0d af=%0d ae=%0d idle=%b err=%h cfg_err=%b",
                             e.name, state, umbral_af, umbral_ae, idle, error_out, cfg_err,
                             e.st, e.af, e.ae, e.idl, e.err, e.cfg);
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        #1 reset_L = 1'b0;
        step(2);
        expect_out("reset_state", 4'd0, 3'd6, 3'd1, 1'b0, 12'h000, 1'b0);

        // Release reset, request config 5/2.
        init = 1'b1; umbral_af_in = 3'd5; umbral_ae_in = 3'd2;
        reset_L = 1'b1;
        step(1);
        expect_out("reset_to_init", 4'd1, 3'd6, 3'd1, 1'b0, 12'h000, 1'b0);
        init = 1'b0;
        step(1);
        expect_out("init_load_5_2", 4'd2, 3'd5, 3'd2, 1'b1, 12'h000, 1'b0);

        // Invalid pair 2/3 keeps 5/2 and flags cfg_err.
        init = 1'b1; umbral_af_in = 3'd2; umbral_ae_in = 3'd3;
        step(1);
        expect_out("idle_to_init", 4'd1, 3'd5, 3'd2, 1'b0, 12'h000, 1'b0);
        step(1);
        expect_out("cfg_invalid_ae_gt_af", 4'd1, 3'd5, 3'd2, 1'b0, 12'h000, 1'b1);
        umbral_af_in = 3'd7; umbral_ae_in = 3'd3;
        step(1);
        expect_out("cfg_valid_af_max", 4'd1, 3'd7, 3'd3, 1'b0, 12'h000, 1'b0);
        umbral_af_in = 3'd4; umbral_ae_in = 3'd0;
        step(1);
        expect_out("cfg_invalid_ae_zero", 4'd1, 3'd7, 3'd3, 1'b0, 12'h000, 1'b1);
        umbral_af_in = 3'd4; umbral_ae_in = 3'd4;
        step(1);
        expect_out("cfg_invalid_equal", 4'd1, 3'd7, 3'd3, 1'b0, 12'h000, 1'b1);
        umbral_af_in = 3'd4; umbral_ae_in = 3'd3; init = 1'b0;
        step(1);
        expect_out("init_load_4_3", 4'd2, 3'd4, 3'd3, 1'b1, 12'h000, 1'b0);

        // IDLE -> ACTIVE on a busy FIFO; thresholds ignore inputs outside INIT.
        empties = 12'hFFE; umbral_af_in = 3'd6; umbral_ae_in = 3'd2;
        step(1);
        expect_out("idle_to_active", 4'd3, 3'd4, 3'd3, 1'b0, 12'h000, 1'b0);
        step(2);
        expect_out("active_hold_busy", 4'd3, 3'd4, 3'd3, 1'b0, 12'h000, 1'b0);
        empties = 12'hFFF;
        for (int i = 0; i < HOLD - 1; i++) begin
            step(1);
            expect_out("active_drain_filter", 4'd3, 3'd4, 3'd3, 1'b0, 12'h000, 1'b0);
        end
        step(1);
        expect_out("active_to_idle", 4'd2, 3'd4, 3'd3, 1'b1, 12'h000, 1'b0);

        // ACTIVE -> INIT without waiting for drain.
        empties = 12'hFFE;
        step(1);
        expect_out("reactivate", 4'd3, 3'd4, 3'd3, 1'b0, 12'h000, 1'b0);
        init = 1'b1; umbral_af_in = 3'd4; umbral_ae_in = 3'd3;
        step(1);
        expect_out("active_to_init", 4'd1, 3'd4, 3'd3, 1'b0, 12'h000, 1'b0);
        init = 1'b0;
        step(2);
        expect_out("back_to_active", 4'd3, 3'd4, 3'd3, 1'b0, 12'h000, 1'b0);

        // Error with simultaneous init: ERROR wins, record is sticky.
        fifo_err = 12'h010; init = 1'b1;
        step(1);
        expect_out("err_beats_init", 4'd4, 3'd4, 3'd3, 1'b0, 12'h010, 1'b0);
        fifo_err = 12'h000;
        step(1);
        expect_out("error_ignores_init", 4'd4, 3'd4, 3'd3, 1'b0, 12'h010, 1'b0);
        fifo_err = 12'h001; init = 1'b0;
        step(1);
        expect_out("error_accumulate", 4'd4, 3'd4, 3'd3, 1'b0, 12'h011, 1'b0);
        fifo_err = 12'h000; init = 1'b1; empties = 12'hFFF;
        step(1);
        expect_out("error_sticky", 4'd4, 3'd4, 3'd3, 1'b0, 12'h011, 1'b0);

        // Async reset leaves ERROR immediately, away from a clock edge.
        #1 reset_L = 1'b0;
        #1;
        expect_out("async_reset_from_error", 4'd0, 3'd6, 3'd1, 1'b0, 12'h000, 1'b0);
        init = 1'b0; empties = 12'hFFE; umbral_af_in = 3'd6; umbral_ae_in = 3'd2;
        reset_L = 1'b1;
        step(1);
        expect_out("post_reset_init", 4'd1, 3'd6, 3'd1, 1'b0, 12'h000, 1'b0);
        step(1);
        expect_out("post_reset_idle", 4'd2, 3'd6, 3'd2, 1'b1, 12'h000, 1'b0);
        step(1);
        expect_out("post_reset_active", 4'd3, 3'd6, 3'd2, 1'b0, 12'h000, 1'b0);

        // Async reset mid-ACTIVE.
        #2 reset_L = 1'b0;
        #1;
        expect_out("async_reset_mid_active", 4'd0, 3'd6, 3'd1, 1'b0, 12'h000, 1'b0);
        init = 1'b1; empties = 12'hFFF;
        reset_L = 1'b1;
        step(1);
        expect_out("rst_release_init", 4'd1, 3'd6, 3'd1, 1'b0, 12'h000, 1'b0);
        step(1);
        expect_out("init_held", 4'd1, 3'd6, 3'd2, 1'b0, 12'h000, 1'b0);
        init = 1'b0;
        step(1);
        expect_out("init_release_idle", 4'd2, 3'd6, 3'd2, 1'b1, 12'h000, 1'b0);

        // Illegal state code recovers through RESET.
        force dut.r_state = 4'd9;
        #1 release dut.r_state;
        step(1);
        expect_out("illegal_to_reset", 4'd0, 3'd6, 3'd2, 1'b0, 12'h000, 1'b0);
        step(1);
        expect_out("illegal_then_init", 4'd1, 3'd6, 3'd2, 1'b0, 12'h000, 1'b0);
        step(1);
        expect_out("illegal_then_idle", 4'd2, 3'd6, 3'd2, 1'b1, 12'h000, 1'b0);

        #5;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
